// File: rtl/pcie_pio_mm_engine.sv
// pcie_pio_mm_engine
//   PIO request engine. Accepts decoded PIO requests (valid/ready) and
//   drives an Avalon-MM master with up to MAX_OUTST pipelined reads, with
//   bursts. In-order read data is buffered in a completion FIFO together
//   with its requester tag. Completion-buffer credits are reserved at read
//   accept, so a readdatavalid beat always has room and is never dropped.
// Ports
//   Clk_i, Rstn_i          clock, synchronous active-low reset
//   req_*                  request channel (write = single beat, posted)
//   pio_*                  Avalon-MM master
//   cpl_*                  completion beats {data, tag, status, last}
//   outst_cnt_o            read commands not yet fully returned
//   timeout_err_o          sticky: no read data for CPL_TIMEOUT cycles
//   unexp_err_o            sticky: readdatavalid with no read outstanding
module pcie_pio_mm_engine #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int TAG_W       = 10,
    parameter int BURST_W     = 4,
    parameter int MAX_OUTST   = 8,
    parameter int CPL_DEPTH   = 32,
    parameter int CPL_TIMEOUT = 4096
) (
    input  logic                         Clk_i,
    input  logic                         Rstn_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_write_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [DATA_W-1:0]            req_data_i,
    input  logic [DATA_W/8-1:0]          req_be_i,
    input  logic [BURST_W-1:0]           req_burst_i,
    input  logic [TAG_W-1:0]             req_tag_i,
    output logic [ADDR_W-1:0]            pio_address_o,
    output logic                         pio_read_o,
    output logic                         pio_write_o,
    output logic [DATA_W-1:0]            pio_writedata_o,
    output logic [DATA_W/8-1:0]          pio_byteenable_o,
    output logic [BURST_W-1:0]           pio_burstcount_o,
    input  logic                         pio_waitrequest_i,
    input  logic [DATA_W-1:0]            pio_readdata_i,
    input  logic                         pio_readdatavalid_i,
    input  logic [1:0]                   pio_response_i,
    output logic                         cpl_valid_o,
    input  logic                         cpl_ready_i,
    output logic [DATA_W-1:0]            cpl_data_o,
    output logic [TAG_W-1:0]             cpl_tag_o,
    output logic [1:0]                   cpl_status_o,
    output logic                         cpl_last_o,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt_o,
    output logic                         timeout_err_o,
    output logic                         unexp_err_o
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int OW = PW + 1;
    localparam int CW = $clog2(CPL_DEPTH);
    localparam int RW = CW + 2;
    localparam int TW = $clog2(CPL_TIMEOUT) + 1;
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    typedef enum logic {S_IDLE, S_CMD} state_t;
    state_t state_q, state_d;

    logic [BURST_W-1:0] req_b;
    logic               rd_room, accept, tag_push, tag_pop, beat_ok, beat_last, cpl_pop;

    logic [TAG_W-1:0]   tag_mem [MAX_OUTST];
    logic [BURST_W-1:0] len_mem [MAX_OUTST];
    logic [PW-1:0]      tag_wp, tag_rp;
    logic [OW-1:0]      outst_q;
    logic [BURST_W-1:0] rx_cnt_q;

    logic [DATA_W-1:0]  cpl_data_mem [CPL_DEPTH];
    logic [TAG_W-1:0]   cpl_tag_mem  [CPL_DEPTH];
    logic [1:0]         cpl_st_mem   [CPL_DEPTH];
    logic               cpl_last_mem [CPL_DEPTH];
    logic [CW-1:0]      cpl_wp, cpl_rp;
    logic [CW:0]        cpl_cnt_q;

    logic [RW-1:0]      reserved_q;
    logic [TW-1:0]      tmo_q;

    assign req_b     = (req_burst_i == '0) ? BURST_ONE : req_burst_i;
    assign rd_room   = (outst_q < OW'(MAX_OUTST)) &&
                       ((reserved_q + RW'(req_b)) <= RW'(CPL_DEPTH));
    // Gated by Rstn_i so that every output, ready included, reads 0 in reset.
    assign req_ready_o = Rstn_i && (state_q == S_IDLE) && (req_write_i || rd_room);
    assign accept    = req_valid_i && req_ready_o;
    assign tag_push  = accept && !req_write_i;
    assign beat_ok   = pio_readdatavalid_i && (outst_q != '0);
    assign beat_last = ((rx_cnt_q + BURST_ONE) == len_mem[tag_rp]);
    assign tag_pop   = beat_ok && beat_last;
    assign cpl_pop   = cpl_valid_o && cpl_ready_i;

    assign outst_cnt_o  = outst_q;
    assign cpl_valid_o  = (cpl_cnt_q != '0);
    assign cpl_data_o   = cpl_valid_o ? cpl_data_mem[cpl_rp] : '0;
    assign cpl_tag_o    = cpl_valid_o ? cpl_tag_mem[cpl_rp]  : '0;
    assign cpl_status_o = cpl_valid_o ? cpl_st_mem[cpl_rp]   : '0;
    assign cpl_last_o   = cpl_valid_o && cpl_last_mem[cpl_rp];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CMD;
            S_CMD:   if (!pio_waitrequest_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            pio_address_o    <= '0;
            pio_read_o       <= 1'b0;
            pio_write_o      <= 1'b0;
            pio_writedata_o  <= '0;
            pio_byteenable_o <= '0;
            pio_burstcount_o <= '0;
        end else if (accept) begin
            pio_address_o    <= req_addr_i;
            pio_read_o       <= !req_write_i;
            pio_write_o      <= req_write_i;
            pio_writedata_o  <= req_write_i ? req_data_i : '0;
            pio_byteenable_o <= req_write_i ? req_be_i : '1;
            pio_burstcount_o <= req_write_i ? BURST_ONE : req_b;
        end else if (state_q == S_CMD && !pio_waitrequest_i) begin
            pio_read_o  <= 1'b0;
            pio_write_o <= 1'b0;
        end
    end

    // Storage arrays carry no reset; occupancy counters define validity.
    always_ff @(posedge Clk_i) begin
        if (tag_push) begin
            tag_mem[tag_wp] <= req_tag_i;
            len_mem[tag_wp] <= req_b;
        end
        if (beat_ok) begin
            cpl_data_mem[cpl_wp] <= pio_readdata_i;
            cpl_tag_mem[cpl_wp]  <= tag_mem[tag_rp];
            cpl_st_mem[cpl_wp]   <= pio_response_i;
            cpl_last_mem[cpl_wp] <= beat_last;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            tag_wp     <= '0;
            tag_rp     <= '0;
            outst_q    <= '0;
            rx_cnt_q   <= '0;
            cpl_wp     <= '0;
            cpl_rp     <= '0;
            cpl_cnt_q  <= '0;
            reserved_q <= '0;
        end else begin
            if (tag_push) tag_wp <= tag_wp + PW'(1);
            if (tag_pop)  tag_rp <= tag_rp + PW'(1);
            case ({tag_push, tag_pop})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
            if (beat_ok) rx_cnt_q <= beat_last ? '0 : rx_cnt_q + BURST_ONE;

            if (beat_ok) cpl_wp <= cpl_wp + CW'(1);
            if (cpl_pop) cpl_rp <= cpl_rp + CW'(1);
            case ({beat_ok, cpl_pop})
                2'b10:   cpl_cnt_q <= cpl_cnt_q + (CW+1)'(1);
                2'b01:   cpl_cnt_q <= cpl_cnt_q - (CW+1)'(1);
                default: cpl_cnt_q <= cpl_cnt_q;
            endcase

            reserved_q <= reserved_q + (tag_push ? RW'(req_b) : RW'(0))
                                     - (cpl_pop  ? RW'(1)     : RW'(0));
        end
    end

    // Timer saturates at CPL_TIMEOUT-1 so it never wraps back under the flag.
    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            tmo_q         <= '0;
            timeout_err_o <= 1'b0;
            unexp_err_o   <= 1'b0;
        end else begin
            if (pio_readdatavalid_i || outst_q == '0) tmo_q <= '0;
            else if (tmo_q != TW'(CPL_TIMEOUT - 1))   tmo_q <= tmo_q + TW'(1);
            if (tmo_q == TW'(CPL_TIMEOUT - 1)) timeout_err_o <= 1'b1;
            if (pio_readdatavalid_i && outst_q == '0) unexp_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcie_pio_mm_engine.sv
// tb_pcie_pio_mm_engine
//   Directed self-checking bench for pcie_pio_mm_engine. Inputs change on the
//   falling clock edge; outputs are sampled on the falling edge.
module tb_pcie_pio_mm_engine;
    localparam int ADDR_W      = 64;
    localparam int DATA_W      = 512;
    localparam int TAG_W       = 10;
    localparam int BURST_W     = 4;
    localparam int MAX_OUTST   = 8;
    localparam int CPL_DEPTH   = 32;
    localparam int CPL_TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    req_valid, req_ready, req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_data;
    logic [DATA_W/8-1:0]     req_be;
    logic [BURST_W-1:0]      req_burst;
    logic [TAG_W-1:0]        req_tag;
    logic [ADDR_W-1:0]       pio_address;
    logic                    pio_read, pio_write;
    logic [DATA_W-1:0]       pio_writedata;
    logic [DATA_W/8-1:0]     pio_byteenable;
    logic [BURST_W-1:0]      pio_burstcount;
    logic                    pio_waitrequest;
    logic [DATA_W-1:0]       pio_readdata;
    logic                    pio_readdatavalid;
    logic [1:0]              pio_response;
    logic                    cpl_valid, cpl_ready;
    logic [DATA_W-1:0]       cpl_data;
    logic [TAG_W-1:0]        cpl_tag;
    logic [1:0]              cpl_status;
    logic                    cpl_last;
    logic [$clog2(MAX_OUTST):0] outst_cnt;
    logic                    timeout_err, unexp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcie_pio_mm_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .BURST_W(BURST_W),
        .MAX_OUTST(MAX_OUTST), .CPL_DEPTH(CPL_DEPTH), .CPL_TIMEOUT(CPL_TIMEOUT)
    ) dut (
        .Clk_i(clk), .Rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
        .req_burst_i(req_burst), .req_tag_i(req_tag),
        .pio_address_o(pio_address), .pio_read_o(pio_read), .pio_write_o(pio_write),
        .pio_writedata_o(pio_writedata), .pio_byteenable_o(pio_byteenable),
        .pio_burstcount_o(pio_burstcount), .pio_waitrequest_i(pio_waitrequest),
        .pio_readdata_i(pio_readdata), .pio_readdatavalid_i(pio_readdatavalid),
        .pio_response_i(pio_response),
        .cpl_valid_o(cpl_valid), .cpl_ready_i(cpl_ready), .cpl_data_o(cpl_data),
        .cpl_tag_o(cpl_tag), .cpl_status_o(cpl_status), .cpl_last_o(cpl_last),
        .outst_cnt_o(outst_cnt), .timeout_err_o(timeout_err), .unexp_err_o(unexp_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one request and returns on the falling edge after it is accepted.
    task automatic send_req(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic [DATA_W/8-1:0] be,
                            input logic [BURST_W-1:0] burst, input logic [TAG_W-1:0] tag);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = data;
        req_be = be; req_burst = burst; req_tag = tag;
        #1;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL req_accept: waited %0d cycles, required < 200", n);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Drives n back-to-back return beats; readdata low word = base+i.
    task automatic drive_beats(input int n, input int base, input int resp_base, input int resp_inc);
        for (int i = 0; i < n; i++) begin
            pio_readdatavalid = 1'b1;
            pio_readdata = '0;
            pio_readdata[31:0] = 32'(base + i);
            pio_response = 2'(resp_base + resp_inc * i);
            @(negedge clk);
        end
        pio_readdatavalid = 1'b0;
    endtask

    // Waits (bounded) for a completion beat, captures it and pops it.
    task automatic pop_beat(output logic ok, output logic [31:0] d, output logic [TAG_W-1:0] t,
                            output logic [1:0] s, output logic l);
        int n = 0;
        while (!cpl_valid && n < 100) begin
            @(negedge clk); n++;
        end
        ok = cpl_valid;
        d = cpl_data[31:0]; t = cpl_tag; s = cpl_status; l = cpl_last;
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, pio_address, pio_read, pio_write, pio_writedata, pio_byteenable,
             pio_burstcount, cpl_valid, cpl_data, cpl_tag, cpl_status, cpl_last,
             outst_cnt, timeout_err, unexp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero (ready=%0b rd=%0b wr=%0b outst=%0d), required all 0",
                     req_ready, pio_read, pio_write, outst_cnt);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%0b, required 1", req_ready);
        end
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] wd;
        wd = {64{8'hA5}};
        pio_waitrequest = 1'b1;
        send_req(1'b1, 64'h1000, wd, '1, 4'd0, 10'h0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pio_write !== 1'b1 || pio_read !== 1'b0 || pio_address !== 64'h1000 ||
                pio_writedata !== wd || pio_byteenable !== {64{1'b1}} || pio_burstcount !== 4'd1) begin
                n_fail++;
                $display("FAIL write_hold[%0d]: wr=%0b rd=%0b addr=%h bc=%0d, required wr=1 rd=0 addr=1000 bc=1",
                         i, pio_write, pio_read, pio_address, pio_burstcount);
            end
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_busy[%0d]: ready=%0b, required 0", i, req_ready);
            end
            if (i == 3) pio_waitrequest = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (pio_write !== 1'b0 || cpl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_end: wr=%0b cpl_valid=%0b, required 0 0", pio_write, cpl_valid);
        end
    endtask

    task automatic test_read_burst();
        logic ok, l; logic [31:0] d; logic [TAG_W-1:0] t; logic [1:0] s;
        send_req(1'b0, 64'h2000, '0, '0, 4'd4, 10'h15);
        n_checks++;
        if (pio_read !== 1'b1 || pio_burstcount !== 4'd4 || pio_byteenable !== {64{1'b1}} ||
            pio_address !== 64'h2000) begin
            n_fail++;
            $display("FAIL read_cmd: rd=%0b bc=%0d addr=%h, required rd=1 bc=4 addr=2000",
                     pio_read, pio_burstcount, pio_address);
        end
        n_checks++;
        if (outst_cnt !== 4'd1 || cpl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_outst1: outst=%0d cpl_valid=%0b, required 1 0", outst_cnt, cpl_valid);
        end
        drive_beats(4, 32'h100, 0, 0);
        n_checks++;
        if (outst_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL read_outst0: outst=%0d, required 0", outst_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            pop_beat(ok, d, t, s, l);
            n_checks++;
            if (!ok || d !== 32'(32'h100 + i) || t !== 10'h15 || s !== 2'd0 || l !== (i == 3)) begin
                n_fail++;
                $display("FAIL read_beat[%0d]: ok=%0b data=%h tag=%h st=%0d last=%0b, required data=%h tag=15 st=0 last=%0b",
                         i, ok, d, t, s, l, 32'h100 + i, (i == 3));
            end
        end
    endtask

    task automatic test_credits();
        int n = 0;
        send_req(1'b0, 64'h3000, '0, '0, 4'd15, 10'h1);
        send_req(1'b0, 64'h4000, '0, '0, 4'd15, 10'h2);
        req_valid = 1'b1; req_write = 1'b0; req_burst = 4'd4; req_tag = 10'h3; req_addr = 64'h5000;
        @(negedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_block: ready=%0b with 30 reserved + 4, required 0", req_ready);
        end
        drive_beats(15, 32'h200, 0, 0);
        #1;
        n_checks++;
        if (req_ready !== 1'b0 || outst_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL credit_nopop: ready=%0b outst=%0d, required 0 1", req_ready, outst_cnt);
        end
        cpl_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_pop1: ready=%0b with 29 reserved + 4, required 0", req_ready);
        end
        @(negedge clk);
        cpl_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_pop2: ready=%0b with 28 reserved + 4, required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (outst_cnt !== 4'd2 || pio_read !== 1'b1 || pio_burstcount !== 4'd4) begin
            n_fail++;
            $display("FAIL credit_accept: outst=%0d rd=%0b bc=%0d, required 2 1 4",
                     outst_cnt, pio_read, pio_burstcount);
        end
        cpl_ready = 1'b1;
        drive_beats(19, 32'h300, 0, 0);
        while (cpl_valid && n < 100) begin
            @(negedge clk); n++;
        end
        cpl_ready = 1'b0;
        n_checks++;
        if (outst_cnt !== 4'd0 || cpl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_drain: outst=%0d cpl_valid=%0b, required 0 0", outst_cnt, cpl_valid);
        end
    endtask

    task automatic test_max_outst();
        logic ok, l; logic [31:0] d; logic [TAG_W-1:0] t; logic [1:0] s;
        for (int i = 0; i < MAX_OUTST; i++)
            send_req(1'b0, 64'(64'h6000 + 64 * i), '0, '0, (i == 0) ? 4'd0 : 4'd1, 10'(10'h20 + i));
        req_valid = 1'b1; req_write = 1'b0; req_burst = 4'd1; req_tag = 10'h3F;
        @(negedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b0 || outst_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL maxout_block: ready=%0b outst=%0d, required 0 8", req_ready, outst_cnt);
        end
        req_write = 1'b1; req_addr = 64'h7000; req_data = '0; req_be = '1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL maxout_write_ready: ready=%0b, required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (pio_write !== 1'b1 || pio_address !== 64'h7000 || outst_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL maxout_write: wr=%0b addr=%h outst=%0d, required 1 7000 8",
                     pio_write, pio_address, outst_cnt);
        end
        @(negedge clk);
        drive_beats(8, 32'h400, 0, 1);
        for (int i = 0; i < MAX_OUTST; i++) begin
            pop_beat(ok, d, t, s, l);
            n_checks++;
            if (!ok || d !== 32'(32'h400 + i) || t !== 10'(10'h20 + i) || s !== 2'(i) || l !== 1'b1) begin
                n_fail++;
                $display("FAIL maxout_beat[%0d]: ok=%0b data=%h tag=%h st=%0d last=%0b, required data=%h tag=%h st=%0d last=1",
                         i, ok, d, t, s, l, 32'h400 + i, 10'h20 + i, i % 4);
            end
        end
    endtask

    task automatic test_timeout();
        logic ok, l; logic [31:0] d; logic [TAG_W-1:0] t; logic [1:0] s;
        send_req(1'b0, 64'h8000, '0, '0, 4'd1, 10'h33);
        repeat (CPL_TIMEOUT - 1) @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: err=%0b at cycle %0d, required 0", timeout_err, CPL_TIMEOUT - 1);
        end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_set: err=%0b at cycle %0d, required 1", timeout_err, CPL_TIMEOUT);
        end
        drive_beats(1, 32'h500, 1, 0);
        pop_beat(ok, d, t, s, l);
        n_checks++;
        if (!ok || d !== 32'h500 || t !== 10'h33 || s !== 2'd1 || l !== 1'b1 ||
            timeout_err !== 1'b1 || outst_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout_late: ok=%0b data=%h tag=%h st=%0d err=%0b outst=%0d, required 1 500 33 1 1 0",
                     ok, d, t, s, timeout_err, outst_cnt);
        end
    endtask

    task automatic test_unexp_and_reset();
        drive_beats(1, 32'h600, 0, 0);
        n_checks++;
        if (unexp_err !== 1'b1 || cpl_valid !== 1'b0 || outst_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL unexp: err=%0b cpl_valid=%0b outst=%0d, required 1 0 0", unexp_err, cpl_valid, outst_cnt);
        end
        send_req(1'b0, 64'h9000, '0, '0, 4'd4, 10'h7);
        drive_beats(2, 32'h700, 0, 0);
        pio_readdatavalid = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, pio_address, pio_read, pio_write, pio_writedata, pio_byteenable,
             pio_burstcount, cpl_valid, cpl_data, cpl_tag, cpl_status, cpl_last,
             outst_cnt, timeout_err, unexp_err} !== '0) begin
            n_fail++;
            $display("FAIL midburst_reset: cpl_valid=%0b outst=%0d unexp=%0b tmo=%0b addr=%h, required all 0",
                     cpl_valid, outst_cnt, unexp_err, timeout_err, pio_address);
        end
        pio_readdatavalid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || cpl_valid !== 1'b0 || outst_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset: ready=%0b cpl_valid=%0b outst=%0d, required 1 0 0",
                     req_ready, cpl_valid, outst_cnt);
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        req_be = '0; req_burst = '0; req_tag = '0; pio_waitrequest = 1'b0;
        pio_readdata = '0; pio_readdatavalid = 1'b0; pio_response = '0; cpl_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read_burst();
        test_credits();
        test_max_outst();
        test_timeout();
        test_unexp_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
